// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-access pipeline stage with req/ack data memory port
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] alu_res,
    input  logic [31:0]       store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic              men2reg,
    input  logic              reg_write,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              out_valid,
    output logic [31:0]       data,
    output logic [ADDR_W-1:0] aluRes,
    output logic              men2reg_out,
    output logic              reg_write_out,
    output logic              misalign_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic [1:0]        r_lane;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [31:0]       r_load_data_q;

    logic              w_mem_op;
    logic              w_misalign;
    logic              w_start;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load_fmt;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    assign w_mem_op = in_valid & (mem_read | mem_write);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (size == 2'b01 && alu_res[0]) ||
                        (size[1] && alu_res[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start = (r_state == IDLE) && w_mem_op && !w_misalign;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data;
        case (size)
            2'b00: begin
                w_be    = 4'b0001 << alu_res[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_be    = alu_res[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

    // Lane select and extension use the captured address/size, not the live inputs.
    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_size)
            2'b00:   w_load_fmt = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_fmt = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_be          <= 4'h0;
            r_wdata       <= 32'h0;
            r_we          <= 1'b0;
            r_lane        <= 2'b00;
            r_size        <= 2'b00;
            r_uns         <= 1'b0;
            r_load_data_q <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_addr  <= {alu_res[ADDR_W-1:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_we    <= mem_write;
                        r_lane  <= alu_res[1:0];
                        r_size  <= size;
                        r_uns   <= load_unsigned;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        r_load_data_q <= r_we ? 32'h0 : w_load_fmt;
                        r_state       <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Control outputs are gated by rst so the stage is quiet while reset is held.
    always_comb begin
        stall         = 1'b0;
        dmem_req      = 1'b0;
        out_valid     = 1'b0;
        data          = 32'h0;
        reg_write_out = 1'b0;
        misalign_err  = 1'b0;
        dmem_we       = r_we;
        dmem_addr     = r_addr;
        dmem_wdata    = r_wdata;
        dmem_be       = r_be;
        aluRes        = alu_res;
        men2reg_out   = men2reg;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op && !w_misalign) begin
                        stall = 1'b1;
                    end else if (w_mem_op && w_misalign) begin
                        out_valid    = 1'b1;
                        misalign_err = 1'b1;
                    end else begin
                        out_valid     = in_valid;
                        reg_write_out = in_valid & reg_write;
                    end
                end
                ACCESS: begin
                    stall    = 1'b1;
                    dmem_req = 1'b1;
                end
                RESP: begin
                    out_valid     = 1'b1;
                    data          = r_load_data_q;
                    reg_write_out = reg_write;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
// Honours LSU_MISALIGN_TRAP_EN to select the expected misaligned behaviour.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] alu_res = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        load_unsigned = 1'b0;
    logic        men2reg = 1'b0;
    logic        reg_write = 1'b0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] data, aluRes;
    logic        men2reg_out, reg_write_out, misalign_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_res(alu_res),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .load_unsigned(load_unsigned), .men2reg(men2reg),
        .reg_write(reg_write), .stall(stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .data(data), .aluRes(aluRes),
        .men2reg_out(men2reg_out), .reg_write_out(reg_write_out),
        .misalign_err(misalign_err)
    );

    // Drives one memory instruction; ack is raised in the ack_n-th request cycle.
    task automatic mem_op(input logic [31:0] addr, input logic [31:0] sd,
                          input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic rw, input logic [31:0] rdata,
                          input int ack_n, output int stall_cyc,
                          output logic [31:0] o_data, output logic o_valid,
                          output logic o_rwo, output logic [31:0] a_seen,
                          output logic [3:0] be_seen, output logic [31:0] wd_seen,
                          output logic we_seen, output logic stable);
        int reqs;
        reqs = 0; stall_cyc = 0; stable = 1'b1;
        a_seen = 32'h0; be_seen = 4'h0; wd_seen = 32'h0; we_seen = 1'b0;
        in_valid = 1'b1; alu_res = addr; store_data = sd; mem_read = rd;
        mem_write = wr; size = sz; load_unsigned = uns; reg_write = rw; men2reg = rd;
        #1;
        for (int k = 0; k < 30 && stall; k++) begin
            stall_cyc++;
            if (dmem_req) begin
                reqs++;
                if (reqs == 1) begin
                    a_seen = dmem_addr; be_seen = dmem_be;
                    wd_seen = dmem_wdata; we_seen = dmem_we;
                end else if (dmem_addr !== a_seen || dmem_be !== be_seen ||
                             dmem_wdata !== wd_seen || dmem_we !== we_seen) begin
                    stable = 1'b0;
                end
                if (reqs == ack_n) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                end
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0; dmem_rdata = 32'h0;
            #1;
        end
        o_data = data; o_valid = out_valid; o_rwo = reg_write_out;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; mem_read = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, stall, out_valid, misalign_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {dmem_req, stall, out_valid, misalign_err});
        end
        n_cmp++;
        if (data !== 32'h0) begin
            n_err++; $display("FAIL reset_data: got %h expected 00000000", data);
        end
        in_valid = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nonmem();
        in_valid = 1'b1; alu_res = 32'h0000_0040; reg_write = 1'b1; men2reg = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, stall, dmem_req, reg_write_out} !== 4'b1001) begin
            n_err++;
            $display("FAIL nonmem_ctrl: got %b expected 1001",
                     {out_valid, stall, dmem_req, reg_write_out});
        end
        n_cmp++;
        if (aluRes !== 32'h0000_0040) begin
            n_err++; $display("FAIL nonmem_alures: got %h expected 00000040", aluRes);
        end
        // A stray ack while idle must not disturb anything.
        in_valid = 1'b0; reg_write = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, stall, dmem_req} !== 3'b000 || data !== 32'h0) begin
            n_err++;
            $display("FAIL idle_ack_ignored: got ctrl=%b data=%h expected 000/00000000",
                     {out_valid, stall, dmem_req}, data);
        end
    endtask

    task automatic test_load_word();
        int sc; logic [31:0] d, a, wd; logic v, rwo, we, st; logic [3:0] be;
        mem_op(32'h100, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hDEAD_BEEF, 1,
               sc, d, v, rwo, a, be, wd, we, st);
        n_cmp++;
        if (sc !== 2) begin n_err++; $display("FAIL lw_stall_cycles: got %0d expected 2", sc); end
        n_cmp++;
        if (a !== 32'h100 || be !== 4'b1111 || we !== 1'b0) begin
            n_err++; $display("FAIL lw_req: got addr=%h be=%b we=%b expected 00000100/1111/0", a, be, we);
        end
        n_cmp++;
        if (d !== 32'hDEAD_BEEF || v !== 1'b1 || rwo !== 1'b1) begin
            n_err++; $display("FAIL lw_result: got data=%h v=%b rw=%b expected deadbeef/1/1", d, v, rwo);
        end
        n_cmp++;
        if (data !== 32'h0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL lw_after: got data=%h v=%b expected 00000000/0", data, out_valid);
        end
    endtask

    task automatic test_load_sub();
        int sc; logic [31:0] d, a, wd; logic v, rwo, we, st; logic [3:0] be;
        mem_op(32'h103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h8012_3456, 1,
               sc, d, v, rwo, a, be, wd, we, st);
        n_cmp++;
        if (d !== 32'hFFFF_FF80 || a !== 32'h100) begin
            n_err++; $display("FAIL lb_signed: got data=%h addr=%h expected ffffff80/00000100", d, a);
        end
        mem_op(32'h103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h8012_3456, 1,
               sc, d, v, rwo, a, be, wd, we, st);
        n_cmp++;
        if (d !== 32'h0000_0080) begin
            n_err++; $display("FAIL lbu: got %h expected 00000080", d);
        end
        mem_op(32'h102, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h8001_7FFF, 2,
               sc, d, v, rwo, a, be, wd, we, st);
        n_cmp++;
        if (d !== 32'hFFFF_8001 || sc !== 3) begin
            n_err++; $display("FAIL lh_signed: got data=%h stall=%0d expected ffff8001/3", d, sc);
        end
        mem_op(32'h100, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h1234_F00D, 1,
               sc, d, v, rwo, a, be, wd, we, st);
        n_cmp++;
        if (d !== 32'h0000_F00D) begin
            n_err++; $display("FAIL lhu_low: got %h expected 0000f00d", d);
        end
    endtask

    task automatic test_store();
        int sc; logic [31:0] d, a, wd; logic v, rwo, we, st; logic [3:0] be;
        mem_op(32'h202, 32'h1234_ABCD, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'hFFFF_FFFF, 4,
               sc, d, v, rwo, a, be, wd, we, st);
        n_cmp++;
        if (we !== 1'b1 || be !== 4'b1100 || wd !== 32'hABCD_ABCD || a !== 32'h200) begin
            n_err++; $display("FAIL sh_req: got we=%b be=%b wd=%h a=%h expected 1/1100/abcdabcd/00000200", we, be, wd, a);
        end
        n_cmp++;
        if (sc !== 5 || st !== 1'b1) begin
            n_err++; $display("FAIL sh_wait: got stall=%0d stable=%b expected 5/1", sc, st);
        end
        n_cmp++;
        if (d !== 32'h0 || v !== 1'b1 || rwo !== 1'b0) begin
            n_err++; $display("FAIL sh_result: got data=%h v=%b rw=%b expected 00000000/1/0", d, v, rwo);
        end
        mem_op(32'h201, 32'h0000_005A, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0, 1,
               sc, d, v, rwo, a, be, wd, we, st);
        n_cmp++;
        if (we !== 1'b1 || be !== 4'b0010 || wd !== 32'h5A5A_5A5A || rwo !== 1'b1) begin
            n_err++; $display("FAIL sb_req: got we=%b be=%b wd=%h rw=%b expected 1/0010/5a5a5a5a/1", we, be, wd, rwo);
        end
        mem_op(32'h204, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1,
               sc, d, v, rwo, a, be, wd, we, st);
        n_cmp++;
        if (be !== 4'b1111 || wd !== 32'hCAFE_F00D || a !== 32'h204) begin
            n_err++; $display("FAIL sw_req: got be=%b wd=%h a=%h expected 1111/cafef00d/00000204", be, wd, a);
        end
    endtask

    task automatic test_reset_mid_access();
        logic bad;
        in_valid = 1'b1; alu_res = 32'h300; mem_read = 1'b1; size = 2'b10; reg_write = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (dmem_req !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_pre: got req=%b expected 1", dmem_req);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dmem_req, stall, out_valid} !== 3'b000) begin
            n_err++; $display("FAIL rst_mid_drop: got %b expected 000", {dmem_req, stall, out_valid});
        end
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read = 1'b0; reg_write = 1'b0; rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (out_valid !== 1'b0 || dmem_req !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_after: got spurious activity=%b expected 0", bad);
        end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        in_valid = 1'b1; alu_res = 32'h101; mem_read = 1'b1; size = 2'b10; reg_write = 1'b1;
        #1;
        n_cmp++;
        if ({misalign_err, dmem_req, stall, out_valid, reg_write_out} !== 5'b10010 || data !== 32'h0) begin
            n_err++; $display("FAIL trap_cycle: got %b data=%h expected 10010/00000000",
                              {misalign_err, dmem_req, stall, out_valid, reg_write_out}, data);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; mem_read = 1'b0; reg_write = 1'b0;
        #1;
        n_cmp++;
        if ({misalign_err, dmem_req, stall} !== 3'b000) begin
            n_err++; $display("FAIL trap_after: got %b expected 000", {misalign_err, dmem_req, stall});
        end
`else
        int sc; logic [31:0] d, a, wd; logic v, rwo, we, st; logic [3:0] be;
        mem_op(32'h101, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0BAD_CAFE, 1,
               sc, d, v, rwo, a, be, wd, we, st);
        n_cmp++;
        if (a !== 32'h100 || be !== 4'b1111 || d !== 32'h0BAD_CAFE) begin
            n_err++; $display("FAIL misalign_word: got a=%h be=%b d=%h expected 00000100/1111/0badcafe", a, be, d);
        end
        n_cmp++;
        if (misalign_err !== 1'b0) begin
            n_err++; $display("FAIL misalign_flag: got %b expected 0", misalign_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_word();
        test_load_sub();
        test_store();
        test_misalign();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage between the EX/MEM pipeline register and the MEM/WB register of the 32-bit pipeline.
- Drives the data memory through a req/ack handshake and formats load data by byte/half/word with sign or zero extension.
- Stalls the upstream pipeline while an access is in flight. Passes the result plus the men2reg/reg_write controls on to MEM/WB.

Parameters:
- ADDR_W, 32, width of address / alu_res path.

Ports:
- clk  in  1  clock
- rst  in  1  reset (asynchronous, active-high)
- in_valid  in  1  EX/MEM holds a valid instruction
- alu_res  in  ADDR_W  ALU result; effective address for memory ops
- store_data  in  32  store operand
- mem_read  in  1  load
- mem_write  in  1  store
- size  in  2  00 byte, 01 half, 10/11 word
- load_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- men2reg  in  1  writeback-select control, passed through
- reg_write  in  1  writeback-enable control, passed through
- stall  out  1  freezes EX/MEM and earlier stages
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address ({alu_res[ADDR_W-1:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  memory completion; read data valid same cycle
- dmem_rdata  in  32  read word
- out_valid  out  1  result valid for MEM/WB
- data  out  32  formatted load data
- aluRes  out  ADDR_W  alu_res passed through
- men2reg_out  out  1  passed through
- reg_write_out  out  1  passed through (qualified)
- misalign_err  out  1  misaligned-access flag

Behaviour:
- Clock and reset: clk; rst asynchronous, active-high. Reset gives state IDLE, load_data_q=0, captured addr/be/wdata/we=0. During reset: dmem_req=0, stall=0, out_valid=0, misalign_err=0, data=0.
- Memory op: in_valid & (mem_read|mem_write). If both are set, the op is a store.
- State IDLE:
  - Non-memory op: zero latency. stall=0, out_valid=in_valid, combinational pass-through.
  - Memory op: stall=1 combinationally. Capture addr, be, wdata and we at the edge, then go to ACCESS.
- State ACCESS:
  - stall=1; dmem_req=1; addr/be/wdata/we come from registers and stay stable until ack.
  - On dmem_ack: register the formatted dmem_rdata into load_data_q (stores write 0), then go to RESP.
  - There is no timeout; the stage waits indefinitely.
- State RESP: stall=0, out_valid=1, data=load_data_q. Upstream advances at this edge; next state is IDLE.
- Latency: a memory op holds stall for 1 + N cycles, where N is the number of cycles from dmem_req to ack (N≥1). Result is valid in the following cycle. Minimum is 3 cycles per memory instruction.
- Stores: out_valid=1 in RESP; reg_write_out follows the reg_write input.
- dmem_ack outside ACCESS is ignored.
- Store lanes:
  - byte: wdata={4{sd[7:0]}}, be=4'b0001<<addr[1:0]
  - half: wdata={2{sd[15:0]}}, be=addr[1]?4'b1100:4'b0011
  - word: wdata=sd, be=4'b1111
- Load lanes:
  - byte: lane=addr[1:0]
  - half: lane=addr[1]
  - Extension per load_unsigned.
- data is 0 whenever state≠RESP.
- Reset mid-ACCESS: dmem_req drops immediately and the access is abandoned. No result is produced.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Trigger: half with addr[0]=1, or word with addr[1:0]≠00, while in IDLE.
  - No request is issued and stall=0.
  - out_valid=1 that cycle, reg_write_out=0, data=0, misalign_err=1 for that cycle only.
- Undefined:
  - Ignored low address bits are dropped (half uses addr[1] only; word uses no low bits).
  - misalign_err is tied to 0.

Test Plan:
- Non-memory op, alu_res=0x0000_0040, reg_write=1 → out_valid=1 same cycle, stall=0, aluRes=0x40, no dmem_req.
- Load word addr 0x100, memory acks 1 cycle after req with rdata=0xDEAD_BEEF → stall high for 2 cycles, dmem_addr=0x100, be=1111. Next cycle data=0xDEAD_BEEF, out_valid=1.
- Load byte addr 0x103, signed, rdata=0x80xx_xxxx → data=0xFFFF_FF80. Same access with load_unsigned=1 → 0x0000_0080.
- Store half addr 0x202, sd=0x1234_ABCD → dmem_we=1, be=1100, wdata=0xABCD_ABCD. Ack delayed 4 cycles keeps stall=1 and addr stable.
- rst asserted during ACCESS → dmem_req=0 immediately, state IDLE. No out_valid after release.
- With LSU_MISALIGN_TRAP_EN, load word at 0x101 → misalign_err=1 for one cycle, no dmem_req, reg_write_out=0. Without the macro → access to 0x100 with be=1111.
